run_length_detector: RTL

- Parametrised successor to the lab's fixed four-in-a-row sequence detector.
- Watches the serial input w, one sample per en strobe, and flags runs of RUN_LEN or more identical bits (all 0s or all 1s).
- Uses a binary FSM with a run-length counter instead of a one-hot chain.
- Adds a level/pulse output mode, a saturating run-hit counter with clear, and visible run status for the board LEDs.
- Sits between the debounced KEY/SW front end and the LEDR/HEX display logic.

---
 rtl/run_det_pkg.sv | 19 +
 rtl/run_length_detector_sat_counter.sv | 32 +++
 rtl/run_length_detector.sv | 84 ++++++++
 3 files changed

// File: rtl/run_det_pkg.sv
// run_det_pkg: shared definitions for the run-length detector.
//   State encoding for the detector FSM and a constant clog2 used for port sizing.
package run_det_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t RUN0 = 2'b01;
    localparam state_t RUN1 = 2'b10;

    // Bits needed to hold values 0..v-1; callers pass RUN_LEN+1 to hold 0..RUN_LEN.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and load-to-1.
//   clock, resetn : clock and synchronous active-low reset
//   clr           : force count to 0 (highest priority after reset)
//   load          : force count to 1
//   inc           : increment, holding at MAX
//   count         : current value
module sat_counter #(
    parameter int          WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!resetn || clr)
            r_count <= '0;
        else if (load)
            r_count <= WIDTH'(1);
        else if (inc && r_count != WIDTH'(MAX))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of RUN_LEN or more identical bits on a strobed serial input.
//   clock, resetn : clock and synchronous active-low reset
//   en, w         : sample strobe and serial data bit
//   pulse_mode    : 0 = level z, 1 = single-cycle z after each qualifying run
//   clr_hits      : synchronous clear of the hit counter
//   z             : registered run-detected flag
//   run_bit       : value of the current run (0 while IDLE)
//   run_len       : current run length, saturating at RUN_LEN
//   hits          : saturating count of qualifying runs
//   state         : FSM state (IDLE=00, RUN0=01, RUN1=10)
module run_length_detector
    import run_det_pkg::*;
#(
    parameter  int RUN_LEN = 4,
    parameter  int CNT_W   = 8,
    localparam int LW      = clog2(RUN_LEN + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic             w,
    input  logic             pulse_mode,
    input  logic             clr_hits,
    output logic             z,
    output logic             run_bit,
    output logic [LW-1:0]    run_len,
    output logic [CNT_W-1:0] hits,
    output logic [1:0]       state
);

    localparam int unsigned HITS_MAX = CNT_W >= 32 ? 32'hFFFF_FFFF : (2 ** CNT_W) - 1;

    state_t r_state, w_next, w_target;
    logic   r_z;
    logic   w_same, w_load, w_inc, w_hit, w_full_next;

    // Every sample selects the run state matching its bit; the run continues only
    // if we are already in that state (IDLE and the unreachable 11 never match).
    assign w_target    = w ? RUN1 : RUN0;
    assign w_same      = r_state == w_target;
    assign w_load      = en && !w_same;
    assign w_inc       = en && w_same;
    assign w_hit       = w_inc && run_len == LW'(RUN_LEN - 1);
    assign w_full_next = w_hit || (run_len == LW'(RUN_LEN) && !w_load);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_z     <= pulse_mode ? w_hit : w_full_next;
        end
    end

    always_comb begin
        w_next = en ? w_target : r_state;
    end

    always_comb begin
        state   = r_state;
        run_bit = r_state == RUN1;
        z       = r_z;
    end

    sat_counter #(.WIDTH(LW), .MAX(RUN_LEN)) u_run_len (
        .clock (clock),
        .resetn(resetn),
        .clr   (1'b0),
        .load  (w_load),
        .inc   (w_inc),
        .count (run_len)
    );

    sat_counter #(.WIDTH(CNT_W), .MAX(HITS_MAX)) u_hits (
        .clock (clock),
        .resetn(resetn),
        .clr   (clr_hits),
        .load  (1'b0),
        .inc   (w_hit),
        .count (hits)
    );

endmodule
